// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter: accepts an n-bit word when idle and streams it MSB-first, one bit per enabled clock.
// First bit is valid one edge after the handshake; load_ready is held low for the whole stream; en=0 stalls the stream.
module piso_shifter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [n-1:0] load_data,
  output logic         load_ready,
  input  logic         en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST_IDX = CW'(n - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [n-1:0]   r_shreg;
  logic [n-1:0]   w_shreg_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_at_last;

  assign w_at_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // Acceptance depends only on load_valid; en gates shifting, not loading.
        if (load_valid) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = load_data;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (en) begin
          if (w_at_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_shreg_nxt = {r_shreg[n-2:0], 1'b0};
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs depend on registered state only, so no input-to-output timing path exists.
  assign load_ready = (r_state == S_IDLE);
  assign ser_valid  = (r_state == S_SHIFT);
  assign ser_out    = (r_state == S_SHIFT) & r_shreg[n-1];
  assign ser_last   = (r_state == S_SHIFT) & w_at_last;

endmodule
